// File: rtl/nanov_periph_pkg.sv
// Shared constants, UART state type and counter sizing helper for the nanoV
// store peripheral.
package nanov_periph_pkg;

  localparam logic [31:0] GPIO_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] UART_ADDR_DEF = 32'h1000_0004;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Bits needed to hold CLK_DIV-1 in the bit timer.
  function automatic int unsigned div_cnt_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/nanov_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
module nanov_uart_tx
  import nanov_periph_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_byte,
  output logic       full,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = div_cnt_width(CLK_DIV);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DEPTH_P    = PW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  uart_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] count;
  logic          empty;
  logic          push_ok;
  logic          pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_P);
  assign push_ok = push && !full;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pop       = 1'b0;

    unique case (state_q)
      UART_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = UART_START;
          timer_d = TIMER_LOAD;
        end
      end
      UART_START: begin
        if (timer_q == '0) begin
          state_d   = UART_DATA;
          timer_d   = TIMER_LOAD;
          bit_cnt_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      UART_DATA: begin
        if (timer_q == '0) begin
          timer_d = TIMER_LOAD;
          if (bit_cnt_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      UART_STOP: begin
        if (timer_q == '0) begin
          // Chain straight into the next start bit so queued frames abut.
          if (!empty) begin
            pop     = 1'b1;
            state_d = UART_START;
            timer_d = TIMER_LOAD;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase

    busy_d = (wr_ptr_d != rd_ptr_d) || (state_d != UART_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= UART_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/nanov_store_periph.sv
// Store-decoded peripheral behind the nanoV core: GPIO output register and
// UART transmitter, addressed by full 32-bit compare on the latched address.
module nanov_store_periph
  import nanov_periph_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] GPIO_ADDR  = GPIO_ADDR_DEF,
  parameter logic [31:0] UART_ADDR  = UART_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data_out,
  input  logic        store_addr_out,
  input  logic        store_data_out,
  output logic [31:0] gpio_out,
  output logic        uart_tx,
  output logic        uart_busy,
  output logic        uart_overflow
);

  logic [31:0] addr_q, addr_d;
  logic        addr_valid_q, addr_valid_d;
  logic [31:0] gpio_q, gpio_d;
  logic        overflow_q, overflow_d;

  logic [31:0] wdata;
  logic        data_take;
  logic        uart_push;
  logic        uart_full;

  always_comb begin
    for (int unsigned i = 0; i < 32; i++) begin
      wdata[i] = data_out[31-i];
    end
  end

  // An address strobe in the same cycle masks the data strobe.
  assign data_take = store_data_out && !store_addr_out && addr_valid_q;
  assign uart_push = data_take && (addr_q == UART_ADDR);

  always_comb begin
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    gpio_d       = gpio_q;
    overflow_d   = overflow_q | (uart_push && uart_full);
    if (store_addr_out) begin
      addr_d       = data_out;
      addr_valid_d = 1'b1;
    end else if (data_take) begin
      addr_valid_d = 1'b0;
      if (addr_q == GPIO_ADDR) begin
        gpio_d = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      gpio_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      gpio_q       <= gpio_d;
      overflow_q   <= overflow_d;
    end
  end

  nanov_uart_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_uart_tx (
    .clk      (clk),
    .rstn     (rstn),
    .push     (uart_push),
    .push_byte(wdata[7:0]),
    .full     (uart_full),
    .busy     (uart_busy),
    .tx       (uart_tx)
  );

  assign gpio_out      = gpio_q;
  assign uart_overflow = overflow_q;

endmodule

// File: tb/tb_nanov_store_periph.sv
// Self-checking bench for nanov_store_periph: directed scenarios plus random
// stores, compared every cycle against a frame-level behavioural model.
module tb_nanov_store_periph;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] GA = 32'h1000_0000;
  localparam logic [31:0] UA = 32'h1000_0004;
  localparam logic [31:0] OA = 32'h2000_0000;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] data_out = '0;
  logic        sa = 1'b0;
  logic        sd = 1'b0;
  logic [31:0] gpio_out;
  logic        uart_tx, uart_busy, uart_overflow;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_addr;
  bit          m_av;
  logic [31:0] m_gpio;
  bit          m_ovf;
  logic [7:0]  m_q[$];
  bit          m_act;
  int          m_cyc;
  logic [7:0]  m_cur;

  nanov_store_periph #(
    .CLK_DIV   (D),
    .FIFO_DEPTH(DEPTH),
    .GPIO_ADDR (GA),
    .UART_ADDR (UA)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_out      (data_out),
    .store_addr_out(sa),
    .store_data_out(sd),
    .gpio_out      (gpio_out),
    .uart_tx       (uart_tx),
    .uart_busy     (uart_busy),
    .uart_overflow (uart_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic void model_reset();
    m_addr = '0;
    m_av   = 1'b0;
    m_gpio = '0;
    m_ovf  = 1'b0;
    m_q.delete();
    m_act  = 1'b0;
    m_cyc  = 0;
    m_cur  = '0;
  endfunction

  // One clock edge of the model, using the inputs currently driven.
  function automatic void model_edge();
    int          s;
    bit          push;
    logic [7:0]  pb;
    logic [31:0] w;
    s    = m_q.size();
    push = 1'b0;
    pb   = '0;
    if (sa) begin
      m_addr = data_out;
      m_av   = 1'b1;
    end else if (sd && m_av) begin
      m_av = 1'b0;
      w    = rev32(data_out);
      if (m_addr == GA) m_gpio = w;
      else if (m_addr == UA) begin
        push = 1'b1;
        pb   = w[7:0];
      end
    end
    if (m_act) begin
      m_cyc++;
      if (m_cyc == 10 * D) m_act = 1'b0;
    end
    if (!m_act && s > 0) begin
      m_cur = m_q.pop_front();
      m_act = 1'b1;
      m_cyc = 0;
    end
    if (push) begin
      if (s == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(pb);
    end
  endfunction

  function automatic logic exp_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_cyc / D;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  function automatic logic exp_busy();
    return m_act || (m_q.size() != 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("gpio", gpio_out, m_gpio);
    check("tx", {31'd0, uart_tx}, {31'd0, exp_tx()});
    check("busy", {31'd0, uart_busy}, {31'd0, exp_busy()});
    check("ovf", {31'd0, uart_overflow}, {31'd0, m_ovf});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input int gap, input bit clash);
    data_out = addr;
    sa = 1'b1;
    sd = clash;
    tick();
    sa = 1'b0;
    sd = 1'b0;
    data_out = $urandom;
    repeat (gap) tick();
    data_out = rev32(data);
    sd = 1'b1;
    tick();
    sd = 1'b0;
    data_out = $urandom;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (uart_busy && n < max) begin
      tick();
      n++;
    end
    check(tag, {31'd0, uart_busy}, 32'd0);
  endtask

  initial begin
    int bc;
    logic [31:0] a;
    model_reset();

    #1 rstn = 1'b0;
    #10;
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_busy", {31'd0, uart_busy}, 32'd0);
    check("rst_ovf", {31'd0, uart_overflow}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // GPIO store, CPU-typical 32-clock spacing
    store(GA, 32'hA5A5_0F0F, 31, 1'b0);
    check("gpio_a5", gpio_out, 32'hA5A5_0F0F);
    check("gpio_no_uart", {31'd0, uart_busy}, 32'd0);
    idle(2);

    // Single UART byte 0x55: busy spans push cycle plus one frame
    store(UA, 32'h0000_0055, 2, 1'b0);
    bc = 1;
    while (uart_busy && bc < 200) begin
      tick();
      if (uart_busy) bc++;
    end
    check("busy_len", bc, 41);
    idle(3);

    // Burst of UART stores filling the FIFO past capacity
    for (int i = 0; i < 6; i++) store(UA, 32'h0000_00C0 + i, 0, 1'b0);
    check("burst_ovf", {31'd0, uart_overflow}, 32'd1);
    drain("burst_drain", 400);
    check("ovf_sticky", {31'd0, uart_overflow}, 32'd1);

    // Orphan data strobe, then store to unmapped address
    data_out = rev32(32'hDEAD_BEEF);
    sd = 1'b1;
    tick();
    sd = 1'b0;
    store(OA, 32'h1234_5678, 3, 1'b0);
    idle(2);
    check("unmapped_gpio", gpio_out, 32'hA5A5_0F0F);
    check("unmapped_busy", {31'd0, uart_busy}, 32'd0);

    // Async reset in the middle of a frame with more bytes queued
    store(UA, 32'h0000_0033, 0, 1'b0);
    store(UA, 32'h0000_0099, 0, 1'b0);
    store(UA, 32'h0000_00F1, 0, 1'b0);
    idle(8);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check("mid_rst_busy", {31'd0, uart_busy}, 32'd0);
    check("mid_rst_gpio", gpio_out, 32'd0);
    check("mid_rst_ovf", {31'd0, uart_overflow}, 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle(100);

    // Second address strobe overrides the first
    data_out = UA;
    sa = 1'b1;
    tick();
    data_out = GA;
    tick();
    sa = 1'b0;
    tick();
    data_out = rev32(32'h0000_0001);
    sd = 1'b1;
    tick();
    sd = 1'b0;
    check("readdr_gpio", gpio_out, 32'h0000_0001);
    idle(2);
    check("readdr_busy", {31'd0, uart_busy}, 32'd0);

    // Random stores against the model
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: a = GA;
        1, 2: a = UA;
        default: a = OA;
      endcase
      store(a, $urandom, $urandom_range(0, 6), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 30));
    end
    drain("rand_drain", 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
